// File: rtl/freq_meas_sched.sv
// freq_meas_sched: time-shares one edge-counting core across NCH channels, gating a window per enabled channel
module freq_meas_sched #(
  parameter int NCH = 4,
  parameter int CW = $clog2(NCH),
  parameter int SETTLE_CYC = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic           cont,
  input  logic [NCH-1:0] ch_mask,
  input  logic [31:0]    gate_len,
  input  logic [31:0]    cnt_in,
  output logic [CW-1:0]  sel,
  output logic           busy,
  output logic           res_valid,
  output logic [CW-1:0]  res_ch,
  output logic [31:0]    res_cnt,
  output logic           sweep_done
);
  typedef enum logic [1:0] {IDLE, SETTLE, GATE, EMIT} state_t;
  state_t state, state_n;
  logic [NCH-1:0] m_lat;
  logic [31:0] g_lat, s_snap, cnt;
  logic [CW-1:0] lo_sel, nx_sel;
  logic has_nx, cfg_ok, accept, emit_go, relatch, done_n;
  always_comb begin
    lo_sel = '0;
    nx_sel = '0;
    has_nx = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) lo_sel = CW'(i);
      if (m_lat[i] && i > int'(sel)) begin
        nx_sel = CW'(i);
        has_nx = 1'b1;
      end
    end
  end
  always_comb begin
    cfg_ok = |ch_mask && |gate_len;
    accept = state == IDLE && start && !abort && cfg_ok;
    emit_go = state == EMIT && !abort;
    relatch = emit_go && !has_nx && cont;
    done_n = emit_go && !has_nx && !cont;
    busy = state != IDLE;
    res_valid = state == EMIT;
    state_n = state;
    if (abort && state != IDLE) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = accept ? SETTLE : IDLE;
        SETTLE:  state_n = cnt == 32'(SETTLE_CYC - 1) ? GATE : SETTLE;
        GATE:    state_n = cnt == g_lat - 32'd1 ? EMIT : GATE;
        default: state_n = (has_nx || (cont && cfg_ok)) ? SETTLE : IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      sel <= '0;
      res_ch <= '0;
      res_cnt <= '0;
      sweep_done <= 1'b0;
      m_lat <= '0;
      g_lat <= '0;
      s_snap <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      sweep_done <= done_n;
      cnt <= (state_n == state && state != IDLE) ? cnt + 32'd1 : '0;
      if (accept || relatch) begin
        m_lat <= ch_mask;
        g_lat <= gate_len;
      end
      if (accept || (relatch && cfg_ok)) sel <= lo_sel;
      else if (emit_go && has_nx) sel <= nx_sel;
      if (state == SETTLE && state_n == GATE) s_snap <= cnt_in;
      // modulo subtraction absorbs a counter wrap inside the window
      if (state == GATE && state_n == EMIT) begin
        res_cnt <= cnt_in - s_snap;
        res_ch <= sel;
      end
    end
  end
endmodule

// File: doc/freq_meas_sched.md
Name: freq_meas_sched

Overview:
- Time-shares one freq_cnt edge-counting core among NCH ADC channels.
- For each enabled channel in turn, it drives the input mux select and waits a settle interval for the core and pipeline to flush. It then gates a measurement window of gate_len clk cycles and reports the edge-count delta tagged with the channel number.
- Sits between the channel mux/freq_cnt pair and the register/readout logic.
- Supports single-sweep and continuous round-robin modes.

Parameters:
- NCH, 4: number of shared input channels (2..16).
- CW, $clog2(NCH): width of the channel select/tag.
- SETTLE_CYC, 16: cycles spent in SETTLE after each mux switch (>=1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  sweep request; sampled in IDLE only.
- abort  in  1  synchronous abort of any sweep in progress.
- cont  in  1  1 = continuous round-robin, 0 = single sweep.
- ch_mask  in  NCH  enabled channels; bit i = channel i.
- gate_len  in  32  gate window length in clk cycles.
- cnt_in  in  32  cumulative edge count from the freq_cnt core (cnt_out); free-running, wraps mod 2^32.
- sel  out  CW  mux select to the channel mux feeding freq_cnt.
- busy  out  1  high while a sweep is active.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  CW  channel of the current result.
- res_cnt  out  32  edges counted in the gate window.
- sweep_done  out  1  one-cycle pulse when a single sweep completes.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE. sel, busy, res_valid, res_ch, res_cnt and sweep_done are all 0, as are the internal snapshots and counters. A reset mid-sweep discards everything, with no result strobe.
- States: IDLE, SETTLE, GATE, EMIT.
- IDLE:
  - start=1 is accepted when ch_mask!=0 and gate_len!=0. Otherwise it is ignored and the block stays IDLE.
  - On accept: latch ch_mask into m_lat and gate_len into g_lat, set sel = lowest set bit of m_lat, go to SETTLE, busy=1 from the next cycle.
- SETTLE: lasts exactly SETTLE_CYC cycles. On the edge leaving SETTLE, s_snap <= cnt_in, then go to GATE.
- GATE: lasts exactly g_lat cycles. On the edge leaving GATE, e_snap <= cnt_in, then go to EMIT.
- EMIT: lasts 1 cycle.
  - res_valid=1, res_ch=sel, res_cnt = e_snap - s_snap as an unsigned 32-bit modulo subtraction, so counter wrap is handled.
  - res_ch and res_cnt hold their value until the next EMIT.
- After EMIT:
  - If a set bit of m_lat exists above sel: sel = next such bit, go to SETTLE.
  - Else if cont=1: re-latch ch_mask and gate_len. If the new mask or gate_len is zero, go to IDLE (busy=0, no sweep_done). Otherwise sel = lowest set bit, go to SETTLE.
  - Else: go to IDLE; sweep_done=1 for the cycle in IDLE immediately after EMIT; busy=0.
- sel changes only on entry to SETTLE and is otherwise stable. Per-channel slot time = SETTLE_CYC + g_lat + 1 cycles.
- start while busy is ignored. Changes to ch_mask or gate_len mid-sweep have no effect until the next (re)latch.
- abort=1 in any non-IDLE state goes to IDLE on the next edge: busy=0, res_valid=0, no sweep_done. sel holds its value. abort has priority over all state transitions. abort in IDLE is a no-op; start and abort together in IDLE means start is ignored.
- res_valid and sweep_done are never high in the same cycle.

Test Plan:
- Single channel, one-shot: ch_mask=4'b0001, gate_len=400, SETTLE_CYC=16, cont=0; the bench model increments cnt_in by 1 every 4 cycles. Required: one res_valid with res_ch=0 and res_cnt=100±1; sweep_done exactly 1 cycle later; busy high for 16+400+1 cycles.
- Multi-channel ordering: ch_mask=4'b1010, gate_len=200; the bench cnt rate depends on sel (ch1: every 2 cycles, ch3: every 10 cycles). Required: results in order (1, 100±1) then (3, 20±1); sel=1 then 3; channels 0 and 2 never selected.
- Counter wrap: cnt_in starts at 0xFFFF_FFF0 and increments every cycle, gate_len=32. Required: res_cnt=32.
- Continuous mode with live reconfiguration: cont=1, ch_mask=4'b0011, gate_len=50. Change ch_mask to 4'b0100 during channel 0's GATE. Required: the sequence is ch0, ch1, ch2, ch2, ... with no sweep_done. Then set ch_mask=0. Required: IDLE after the current EMIT, busy=0.
- Abort and reset mid-gate: assert abort 10 cycles into GATE. Required: IDLE next cycle, no res_valid, no sweep_done. Repeat with rstn=0 instead. Required: all outputs 0.
- Illegal start: start with ch_mask=0, then start with gate_len=0. Required: busy stays 0 and no strobes.
